mux_nway_2ph: RTL and testbench
===============================

// Module: mux_nway_2ph
// PURPOSE
//  Clocked N-input, 2-phase (toggle) bundled-data channel multiplexer for the GCD datapath and later pipelines.
//  Forwards one token from a chosen input channel to the single output channel C.
//  MODE 0: the input is chosen by a token on the select channel (steered mux).
//  MODE 1: round-robin merge of pending inputs; the select channel is unused.
//  Output carries the source index so downstream stages can route by origin.
// PARAMETERS
//  DATA_WIDTH  32  width of each data bundle
//  NUM_IN      2   number of input channels, >=2
//  MODE        0   0 = select-steered mux, 1 = round-robin merge
//  localparam IDX_W = max(1, $clog2(NUM_IN))
// PORTS
//  i_clk        in   1                 clock, rising edge
//  i_rstn       in   1                 asynchronous reset, active low
//  o_outC_req   out  1                 output request phase (toggles once per token)
//  o_outC_data  out  DATA_WIDTH        output data, stable while a token is outstanding
//  o_outC_idx   out  IDX_W             index of the source input of the current token
//  i_outC_ack   in   1                 output acknowledge phase
//  i_in_req     in   NUM_IN            per-input request phase
//  i_in_data    in   NUM_IN*DATA_WIDTH input data; channel k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//  o_in_ack     out  NUM_IN            per-input acknowledge phase
//  i_inSel_req  in   1                 select-channel request phase (MODE 0)
//  i_selector   in   IDX_W             select value, bundled with i_inSel_req
//  o_inSel_ack  out  1                 select-channel acknowledge phase (held 0 in MODE 1)
//  o_sel_err    out  1                 one-cycle pulse: select value >= NUM_IN
// BEHAVIOUR
//  - All handshake inputs are synchronous to i_clk. Token pending on channel X <=> X_req != X_ack.
//  - Reset (i_rstn=0, async): all outputs 0, state IDLE, round-robin pointer 0, data/idx regs 0.
//  - Reset mid-transfer discards the outstanding token. Environment phases must also return to 0.
//  - FSM states: IDLE, WAIT_ACK.
//  - IDLE, MODE 0: needs a select token with i_selector=k<NUM_IN and a pending token on input k.
//  - On that edge: o_outC_data <= input k data, o_outC_idx <= k, o_outC_req toggles, go to WAIT_ACK.
//  - IDLE, MODE 0, select value >= NUM_IN: toggle o_inSel_ack, pulse o_sel_err for 1 cycle.
//    No input is consumed; stay in IDLE.
//  - IDLE, MODE 0, select token present but input k not pending: wait. Other inputs are never consumed.
//  - IDLE, MODE 1: grant the first pending input searching from the pointer upward, with wrap.
//    Capture and toggle as in MODE 0; pointer <= (k+1) mod NUM_IN.
//  - WAIT_ACK: on the edge where i_outC_ack == o_outC_req, toggle o_in_ack[k].
//    Also toggle o_inSel_ack in MODE 0. Go to IDLE.
//  - No new token is ever captured while in WAIT_ACK.
//  - Latency: o_outC_req toggles 1 cycle after both required tokens are visible.
//    Input ack toggles 1 cycle after the output ack arrives.
//  - Minimum 2 cycles per token, since IDLE and WAIT_ACK each take at least one cycle.
//  - o_outC_data and o_outC_idx change only on a capture edge. They are held otherwise.
//  - Tokens on non-selected inputs stay pending. Their acks are untouched.
//  - Simultaneous pending inputs in MODE 1: the lowest index at or above the pointer wins.
//  - Phase wrap is free. A token counts whether req is 0->1 or 1->0; only req/ack inequality matters.
// TESTING
//  1. MODE0, NUM_IN=2: sel token sel=1, in1 token data=0xDEADBEEF.
//     -> outC_req 0->1 next cycle, data=0xDEADBEEF, idx=1.
//     After outC_ack 0->1: in_ack[1] and inSel_ack toggle 1 cycle later; in_ack[0] stays 0.
//  2. MODE0: in0 token, then sel=0 token 5 cycles later.
//     -> no outC_req change until the cycle after the sel token arrives; then data=in0.
//  3. MODE0, NUM_IN=3: sel=3 token.
//     -> inSel_ack toggles, o_sel_err high exactly 1 cycle, outC_req unchanged, in_ack all unchanged.
//  4. MODE1, NUM_IN=4: all four inputs pending at once, ack returned each time.
//     -> grants in order idx 0,1,2,3.
//     Re-raise in0 and in2 -> next grant idx=0 (pointer wrapped).
//  5. Back-to-back: 8 tokens in alternating phases on in0 (MODE1, ack zero-delay).
//     -> 8 outC_req toggles, data in order, ≥2 cycles apart, none lost or duplicated.
//  6. Reset asserted in WAIT_ACK.
//     -> all outputs 0 immediately (async). After release with env phases at 0, scenario 1 passes.

Source files
------------

// File: rtl/mux_nway_2ph.sv
// Clocked N-input 2-phase bundled-data multiplexer: select-steered (MODE 0) or
// round-robin merge (MODE 1), forwarding one token at a time with its source index.
module mux_nway_2ph #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 2,
  parameter int MODE       = 0,
  localparam int IDX_W     = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  output logic                         o_outC_req,
  output logic [DATA_WIDTH-1:0]        o_outC_data,
  output logic [IDX_W-1:0]             o_outC_idx,
  input  logic                         i_outC_ack,
  input  logic [NUM_IN-1:0]            i_in_req,
  input  logic [NUM_IN*DATA_WIDTH-1:0] i_in_data,
  output logic [NUM_IN-1:0]            o_in_ack,
  input  logic                         i_inSel_req,
  input  logic [IDX_W-1:0]             i_selector,
  output logic                         o_inSel_ack,
  output logic                         o_sel_err
);

  typedef enum logic {IDLE, WAIT_ACK} stateT;

  stateT                 state, stateNext;
  logic                  outReq, outReqNext;
  logic [DATA_WIDTH-1:0] outData, outDataNext;
  logic [IDX_W-1:0]      outIdx, outIdxNext;
  logic [NUM_IN-1:0]     inAck, inAckNext;
  logic                  selAck, selAckNext;
  logic                  selErr, selErrNext;
  logic [IDX_W-1:0]      rrPtr, rrPtrNext;

  logic [DATA_WIDTH-1:0] inDataArr [NUM_IN];
  logic [NUM_IN-1:0]     pending;
  logic                  selPending;
  logic                  selInRange;
  logic                  rrFound;
  logic [IDX_W-1:0]      rrGrant;
  int                    cand;

  for (genvar k = 0; k < NUM_IN; k++) begin : gUnpack
    assign inDataArr[k] = i_in_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // A token is pending wherever request and acknowledge phases differ.
  assign pending    = i_in_req ^ inAck;
  assign selPending = i_inSel_req ^ selAck;
  assign selInRange = int'(i_selector) < NUM_IN;

  // Scan downward from the farthest offset so the nearest pending input at or
  // above the pointer is the one left standing.
  always_comb begin
    rrFound = 1'b0;
    rrGrant = '0;
    cand    = 0;
    for (int j = NUM_IN - 1; j >= 0; j--) begin
      cand = (int'(rrPtr) + j) % NUM_IN;
      if (pending[cand]) begin
        rrFound = 1'b1;
        rrGrant = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    stateNext   = state;
    outReqNext  = outReq;
    outDataNext = outData;
    outIdxNext  = outIdx;
    inAckNext   = inAck;
    selAckNext  = selAck;
    selErrNext  = 1'b0;
    rrPtrNext   = rrPtr;
    case (state)
      IDLE: begin
        if (MODE == 0) begin
          if (selPending) begin
            if (!selInRange) begin
              selAckNext = ~selAck;
              selErrNext = 1'b1;
            end else if (pending[i_selector]) begin
              outDataNext = inDataArr[i_selector];
              outIdxNext  = i_selector;
              outReqNext  = ~outReq;
              stateNext   = WAIT_ACK;
            end
          end
        end else if (rrFound) begin
          outDataNext = inDataArr[rrGrant];
          outIdxNext  = rrGrant;
          outReqNext  = ~outReq;
          rrPtrNext   = IDX_W'((int'(rrGrant) + 1) % NUM_IN);
          stateNext   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (i_outC_ack == outReq) begin
          inAckNext[outIdx] = ~inAck[outIdx];
          if (MODE == 0) selAckNext = ~selAck;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      outReq  <= 1'b0;
      outData <= '0;
      outIdx  <= '0;
      inAck   <= '0;
      selAck  <= 1'b0;
      selErr  <= 1'b0;
      rrPtr   <= '0;
    end else begin
      state   <= stateNext;
      outReq  <= outReqNext;
      outData <= outDataNext;
      outIdx  <= outIdxNext;
      inAck   <= inAckNext;
      selAck  <= selAckNext;
      selErr  <= selErrNext;
      rrPtr   <= rrPtrNext;
    end
  end

  assign o_outC_req  = outReq;
  assign o_outC_data = outData;
  assign o_outC_idx  = outIdx;
  assign o_in_ack    = inAck;
  assign o_inSel_ack = selAck;
  assign o_sel_err   = selErr;

endmodule

// File: tb/tb_mux_nway_2ph.sv
// Directed bench for mux_nway_2ph: two steered instances (2 and 3 inputs) and
// one 4-input round-robin instance sharing clock and reset.
module tb_mux_nway_2ph;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  logic        aOutReq, aOutAck, aSelReq, aSelAck, aSelErr;
  logic [31:0] aOutData;
  logic [0:0]  aOutIdx, aSel;
  logic [1:0]  aInReq, aInAck;
  logic [63:0] aInData;

  logic        bOutReq, bOutAck, bSelReq, bSelAck, bSelErr;
  logic [31:0] bOutData;
  logic [1:0]  bOutIdx, bSel;
  logic [2:0]  bInReq, bInAck;
  logic [95:0] bInData;

  logic         cOutReq, cOutAck, cSelReq, cSelAck, cSelErr;
  logic [31:0]  cOutData;
  logic [1:0]   cOutIdx, cSel;
  logic [3:0]   cInReq, cInAck;
  logic [127:0] cInData;

  mux_nway_2ph #(.DATA_WIDTH(32), .NUM_IN(2), .MODE(0)) dutA (
    .i_clk(clk), .i_rstn(rstn),
    .o_outC_req(aOutReq), .o_outC_data(aOutData), .o_outC_idx(aOutIdx), .i_outC_ack(aOutAck),
    .i_in_req(aInReq), .i_in_data(aInData), .o_in_ack(aInAck),
    .i_inSel_req(aSelReq), .i_selector(aSel), .o_inSel_ack(aSelAck), .o_sel_err(aSelErr)
  );

  mux_nway_2ph #(.DATA_WIDTH(32), .NUM_IN(3), .MODE(0)) dutB (
    .i_clk(clk), .i_rstn(rstn),
    .o_outC_req(bOutReq), .o_outC_data(bOutData), .o_outC_idx(bOutIdx), .i_outC_ack(bOutAck),
    .i_in_req(bInReq), .i_in_data(bInData), .o_in_ack(bInAck),
    .i_inSel_req(bSelReq), .i_selector(bSel), .o_inSel_ack(bSelAck), .o_sel_err(bSelErr)
  );

  mux_nway_2ph #(.DATA_WIDTH(32), .NUM_IN(4), .MODE(1)) dutC (
    .i_clk(clk), .i_rstn(rstn),
    .o_outC_req(cOutReq), .o_outC_data(cOutData), .o_outC_idx(cOutIdx), .i_outC_ack(cOutAck),
    .i_in_req(cInReq), .i_in_data(cInData), .o_in_ack(cInAck),
    .i_inSel_req(cSelReq), .i_selector(cSel), .o_inSel_ack(cSelAck), .o_sel_err(cSelErr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearEnv();
    aOutAck = 0; aInReq = '0; aInData = '0; aSelReq = 0; aSel = '0;
    bOutAck = 0; bInReq = '0; bInData = '0; bSelReq = 0; bSel = '0;
    cOutAck = 0; cInReq = '0; cInData = '0; cSelReq = 0; cSel = '0;
  endtask

  task automatic test_reset();
    clearEnv();
    rstn = 0;
    tick(); tick();
    testsRun++;
    if ({aOutReq, aOutData, aOutIdx, aInAck, aSelAck, aSelErr} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_a: got %h expected 0", {aOutReq, aOutData, aOutIdx, aInAck, aSelAck, aSelErr});
    end
    testsRun++;
    if ({bOutReq, bOutData, bOutIdx, bInAck, bSelAck, bSelErr} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_b: got %h expected 0", {bOutReq, bOutData, bOutIdx, bInAck, bSelAck, bSelErr});
    end
    testsRun++;
    if ({cOutReq, cOutData, cOutIdx, cInAck, cSelAck, cSelErr} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_c: got %h expected 0", {cOutReq, cOutData, cOutIdx, cInAck, cSelAck, cSelErr});
    end
    rstn = 1;
    tick();
  endtask

  // Expects all dutA phases at 0 on entry.
  task automatic test_select_basic();
    aInData = {32'hDEADBEEF, 32'h11111111};
    aSel = 1'b1; aSelReq = 1; aInReq[1] = 1;
    tick();
    testsRun++;
    if ({aOutReq, aOutData, aOutIdx} !== {1'b1, 32'hDEADBEEF, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL select_capture: got req/data/idx %b/%h/%b expected 1/deadbeef/1", aOutReq, aOutData, aOutIdx);
    end
    aOutAck = 1;
    #1;
    testsRun++;
    if ({aInAck, aSelAck} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL select_ack_early: got inAck/selAck %b/%b expected 00/0", aInAck, aSelAck);
    end
    tick();
    testsRun++;
    if ({aInAck, aSelAck, aOutReq} !== 4'b1011) begin
      testsFailed++;
      $display("[TB] FAIL select_ack: got inAck/selAck/req %b/%b/%b expected 10/1/1", aInAck, aSelAck, aOutReq);
    end
  endtask

  task automatic test_late_select();
    aInData[31:0] = 32'h0A0A0A0A;
    aInReq[0] = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      testsRun++;
      if ({aOutReq, aInAck} !== 3'b110) begin
        testsFailed++;
        $display("[TB] FAIL late_select_hold[%0d]: got req/inAck %b/%b expected 1/10", i, aOutReq, aInAck);
      end
    end
    aSel = 1'b0; aSelReq = 0;
    tick();
    testsRun++;
    if ({aOutReq, aOutData, aOutIdx} !== {1'b0, 32'h0A0A0A0A, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL late_select_capture: got req/data/idx %b/%h/%b expected 0/0a0a0a0a/0", aOutReq, aOutData, aOutIdx);
    end
    aOutAck = 0;
    tick();
    testsRun++;
    if ({aInAck, aSelAck} !== 3'b110) begin
      testsFailed++;
      $display("[TB] FAIL late_select_ack: got inAck/selAck %b/%b expected 11/0", aInAck, aSelAck);
    end
  endtask

  task automatic test_sel_error();
    bInData = {32'h33333333, 32'h22222222, 32'h11111111};
    bInReq = 3'b001;
    bSel = 2'd3; bSelReq = 1;
    tick();
    testsRun++;
    if ({bSelAck, bSelErr, bOutReq, bInAck} !== 6'b110000) begin
      testsFailed++;
      $display("[TB] FAIL sel_err_pulse: got selAck/err/req/inAck %b/%b/%b/%b expected 1/1/0/000", bSelAck, bSelErr, bOutReq, bInAck);
    end
    tick();
    testsRun++;
    if ({bSelAck, bSelErr, bOutReq, bInAck} !== 6'b100000) begin
      testsFailed++;
      $display("[TB] FAIL sel_err_clear: got selAck/err/req/inAck %b/%b/%b/%b expected 1/0/0/000", bSelAck, bSelErr, bOutReq, bInAck);
    end
    bSel = 2'd0; bSelReq = 0;
    tick();
    testsRun++;
    if ({bOutReq, bOutData, bOutIdx} !== {1'b1, 32'h11111111, 2'd0}) begin
      testsFailed++;
      $display("[TB] FAIL sel_err_recover: got req/data/idx %b/%h/%0d expected 1/11111111/0", bOutReq, bOutData, bOutIdx);
    end
    bOutAck = 1;
    tick();
    testsRun++;
    if ({bInAck, bSelAck} !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL sel_err_recover_ack: got inAck/selAck %b/%b expected 001/0", bInAck, bSelAck);
    end
  endtask

  task automatic test_round_robin();
    int   seq [8] = '{0, 1, 2, 3, 0, 2, 3, 1};
    logic expReq = 1'b0;
    logic [3:0] expAck = 4'b0000;
    for (int k = 0; k < 4; k++) cInData[k*32 +: 32] = 32'hC0DE0000 + k;
    cInReq = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) cInReq = cInReq ^ 4'b0101;
      if (i == 6) cInReq = cInReq ^ 4'b1010;
      tick();
      expReq = ~expReq;
      testsRun++;
      if ({cOutReq, cOutIdx, cOutData} !== {expReq, 2'(seq[i]), 32'hC0DE0000 + seq[i]}) begin
        testsFailed++;
        $display("[TB] FAIL rr_grant[%0d]: got req/idx/data %b/%0d/%h expected %b/%0d/%h",
                 i, cOutReq, cOutIdx, cOutData, expReq, seq[i], 32'hC0DE0000 + seq[i]);
      end
      cOutAck = expReq;
      tick();
      expAck[seq[i]] = ~expAck[seq[i]];
      testsRun++;
      if (cInAck !== expAck) begin
        testsFailed++;
        $display("[TB] FAIL rr_ack[%0d]: got inAck %b expected %b", i, cInAck, expAck);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   got = 0;
    int   lastCycle = -10;
    logic prevReq;
    prevReq = cOutReq;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      if (cOutReq !== prevReq) begin
        testsRun++;
        if (cOutData !== (32'h5A000000 | 32'(got))) begin
          testsFailed++;
          $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", got, cOutData, 32'h5A000000 | 32'(got));
        end
        testsRun++;
        if (cyc - lastCycle < 2) begin
          testsFailed++;
          $display("[TB] FAIL b2b_gap[%0d]: got %0d cycles expected >=2", got, cyc - lastCycle);
        end
        lastCycle = cyc;
        got++;
        prevReq = cOutReq;
        cOutAck = cOutReq;
      end
      if (cInReq[0] == cInAck[0] && sent < 8) begin
        cInData[31:0] = 32'h5A000000 | 32'(sent);
        cInReq[0] = ~cInReq[0];
        sent++;
      end
      tick();
    end
    testsRun++;
    if (got != 8) begin
      testsFailed++;
      $display("[TB] FAIL b2b_count: got %0d tokens expected 8", got);
    end
    tick(); tick(); tick(); tick();
    testsRun++;
    if (cOutReq !== prevReq || cInAck[0] !== cInReq[0]) begin
      testsFailed++;
      $display("[TB] FAIL b2b_quiet: got req/inAck0 %b/%b expected %b/%b", cOutReq, cInAck[0], prevReq, cInReq[0]);
    end
  endtask

  task automatic test_reset_mid();
    aInData = {32'h77777777, 32'h66666666};
    aInReq[1] = ~aInReq[1];
    aSel = 1'b1; aSelReq = ~aSelReq;
    tick();
    testsRun++;
    if (aOutReq !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_setup: got req %b expected 1", aOutReq);
    end
    rstn = 0;
    #1;
    testsRun++;
    if ({aOutReq, aOutData, aOutIdx, aInAck, aSelAck, aSelErr} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_async: got %h expected 0", {aOutReq, aOutData, aOutIdx, aInAck, aSelAck, aSelErr});
    end
    clearEnv();
    tick(); tick();
    rstn = 1;
    tick();
    test_select_basic();
  endtask

  initial begin
    clearEnv();
    test_reset();
    test_select_basic();
    test_late_select();
    test_sel_error();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
